// File: rtl/wb_mem_arbiter_rr.sv
// Two-master (icache/dcache) to one-slave Wishbone arbiter granting whole transactions.
// Round-robin by default; define WB_ARB_DCACHE_PRIO_EN for fixed dcache priority.
module wb_mem_arbiter_rr #(
  parameter int ADR_W  = 27,
  parameter int DATA_W = 256,
  parameter int SEL_W  = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [ADR_W-1:0]  i_adr,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [DATA_W-1:0] i_dat_m,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_dat_s,
  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [ADR_W-1:0]  d_adr,
  input  logic [SEL_W-1:0]  d_sel,
  input  logic [DATA_W-1:0] d_dat_m,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_dat_s,
  output logic              m_cyc,
  output logic              m_stb,
  output logic              m_we,
  output logic [ADR_W-1:0]  m_adr,
  output logic [SEL_W-1:0]  m_sel,
  output logic [DATA_W-1:0] m_dat_m,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_dat_s,
  output logic [CNT_W-1:0]  i_grants,
  output logic [CNT_W-1:0]  d_grants
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last;
  logic [CNT_W-1:0] r_i_cnt;
  logic [CNT_W-1:0] r_d_cnt;
  logic             w_i_req;
  logic             w_d_req;
  logic             w_pick_d;
  logic             w_grant_i;
  logic             w_grant_d;

  assign w_i_req = i_cyc & i_stb;
  assign w_d_req = d_cyc & d_stb;

`ifdef WB_ARB_DCACHE_PRIO_EN
  assign w_pick_d = w_d_req;
`else
  // On a tie, dcache wins only if icache was the last master granted.
  assign w_pick_d = w_d_req & (~w_i_req | ~r_last);
`endif

  // Next-state and grant decision.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_d) begin
          w_state_nxt = ST_SERVE_D;
          w_grant_d   = 1'b1;
        end else if (w_i_req) begin
          w_state_nxt = ST_SERVE_I;
          w_grant_i   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SERVE_I: begin
        if (!i_cyc || m_ack) w_state_nxt = ST_IDLE;
        else                 w_state_nxt = ST_SERVE_I;
      end
      ST_SERVE_D: begin
        if (!d_cyc || m_ack) w_state_nxt = ST_IDLE;
        else                 w_state_nxt = ST_SERVE_D;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bus multiplexing; an ack is only forwarded while the owner still holds cyc.
  always_comb begin
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    m_adr   = {ADR_W{1'b0}};
    m_sel   = {SEL_W{1'b0}};
    m_dat_m = {DATA_W{1'b0}};
    i_ack   = 1'b0;
    d_ack   = 1'b0;
    i_dat_s = {DATA_W{1'b0}};
    d_dat_s = {DATA_W{1'b0}};
    case (r_state)
      ST_SERVE_I: begin
        m_cyc   = i_cyc;
        m_stb   = i_stb;
        m_we    = i_we;
        m_adr   = i_adr;
        m_sel   = i_sel;
        m_dat_m = i_dat_m;
        i_ack   = m_ack & i_cyc;
        i_dat_s = m_dat_s;
      end
      ST_SERVE_D: begin
        m_cyc   = d_cyc;
        m_stb   = d_stb;
        m_we    = d_we;
        m_adr   = d_adr;
        m_sel   = d_sel;
        m_dat_m = d_dat_m;
        d_ack   = m_ack & d_cyc;
        d_dat_s = m_dat_s;
      end
      default: begin
        m_cyc = 1'b0;
      end
    endcase
  end

  // State, last-granted flag and saturating grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b0;
      r_i_cnt <= {CNT_W{1'b0}};
      r_d_cnt <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_i) begin
        r_last  <= 1'b0;
        r_i_cnt <= (r_i_cnt == CNT_MAX) ? r_i_cnt : r_i_cnt + CNT_ONE;
      end else if (w_grant_d) begin
        r_last  <= 1'b1;
        r_d_cnt <= (r_d_cnt == CNT_MAX) ? r_d_cnt : r_d_cnt + CNT_ONE;
      end
    end
  end

  assign i_grants = r_i_cnt;
  assign d_grants = r_d_cnt;

endmodule

// File: tb/tb_wb_mem_arbiter_rr.sv
// Table-driven bench for wb_mem_arbiter_rr; expectations adapt to WB_ARB_DCACHE_PRIO_EN.
module tb_wb_mem_arbiter_rr;

  localparam int ADR_W  = 27;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 4;

`ifdef WB_ARB_DCACHE_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  localparam logic [1:0] G_N = 2'd0;
  localparam logic [1:0] G_I = 2'd1;
  localparam logic [1:0] G_D = 2'd2;

  localparam logic [ADR_W-1:0]  I_ADR = 27'h40;
  localparam logic [ADR_W-1:0]  D_ADR = 27'h80;
  localparam logic [SEL_W-1:0]  I_SEL = 4'hF;
  localparam logic [SEL_W-1:0]  D_SEL = 4'h3;
  localparam logic [DATA_W-1:0] I_DAT = 32'h1111_AAAA;
  localparam logic [DATA_W-1:0] D_DAT = 32'h2222_BBBB;
  localparam logic [DATA_W-1:0] M_DAT = 32'hCAFE_F00D;

  typedef struct {
    logic       rst;
    logic       ir;
    logic       iw;
    logic       dr;
    logic       dw;
    logic       mack;
    logic [1:0] gnt;
    logic [3:0] ig;
    logic [3:0] dg;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic i_cyc, i_stb, i_we, d_cyc, d_stb, d_we, m_ack;
  logic i_ack, d_ack, m_cyc, m_stb, m_we;
  logic [ADR_W-1:0]  i_adr, d_adr, m_adr;
  logic [SEL_W-1:0]  i_sel, d_sel, m_sel;
  logic [DATA_W-1:0] i_dat_m, d_dat_m, i_dat_s, d_dat_s, m_dat_m, m_dat_s;
  logic [CNT_W-1:0]  i_grants, d_grants;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  wb_mem_arbiter_rr #(.ADR_W(ADR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_adr(i_adr), .i_sel(i_sel),
    .i_dat_m(i_dat_m), .i_ack(i_ack), .i_dat_s(i_dat_s),
    .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr), .d_sel(d_sel),
    .d_dat_m(d_dat_m), .d_ack(d_ack), .d_dat_s(d_dat_s),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
    .m_dat_m(m_dat_m), .m_ack(m_ack), .m_dat_s(m_dat_s),
    .i_grants(i_grants), .d_grants(d_grants)
  );

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic ir, input logic iw, input logic dr, input logic dw,
                     input logic mack, input logic [1:0] gnt, input int ig, input int dg);
    vec_t v;
    v.rst = r; v.ir = ir; v.iw = iw; v.dr = dr; v.dw = dw; v.mack = mack;
    v.gnt = gnt; v.ig = 4'(ig); v.dg = 4'(dg);
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic ir, input logic iw, input logic dr,
                       input logic dw, input logic mack);
    rst = r;
    i_cyc = ir; i_stb = ir; i_we = iw;
    d_cyc = dr; d_stb = dr; d_we = dw;
    m_ack = mack;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic              e_cyc, e_we;
    logic [ADR_W-1:0]  e_adr;
    logic [SEL_W-1:0]  e_sel;
    logic [DATA_W-1:0] e_dat;
    e_cyc = (v.gnt == G_I) ? v.ir  : (v.gnt == G_D) ? v.dr  : 1'b0;
    e_we  = (v.gnt == G_I) ? v.iw  : (v.gnt == G_D) ? v.dw  : 1'b0;
    e_adr = (v.gnt == G_I) ? I_ADR : (v.gnt == G_D) ? D_ADR : '0;
    e_sel = (v.gnt == G_I) ? I_SEL : (v.gnt == G_D) ? D_SEL : '0;
    e_dat = (v.gnt == G_I) ? I_DAT : (v.gnt == G_D) ? D_DAT : '0;
    chk("m_cyc", idx, 64'(m_cyc), 64'(e_cyc));
    chk("m_stb", idx, 64'(m_stb), 64'(e_cyc));
    chk("m_we", idx, 64'(m_we), 64'(e_we));
    chk("m_adr", idx, 64'(m_adr), 64'(e_adr));
    chk("m_sel", idx, 64'(m_sel), 64'(e_sel));
    chk("m_dat_m", idx, 64'(m_dat_m), 64'(e_dat));
    chk("i_ack", idx, 64'(i_ack), 64'((v.gnt == G_I) & v.mack));
    chk("d_ack", idx, 64'(d_ack), 64'((v.gnt == G_D) & v.mack));
    chk("i_dat_s", idx, 64'(i_dat_s), 64'((v.gnt == G_I) ? M_DAT : 32'h0));
    chk("d_dat_s", idx, 64'(d_dat_s), 64'((v.gnt == G_D) ? M_DAT : 32'h0));
    chk("i_grants", idx, 64'(i_grants), 64'(v.ig));
    chk("d_grants", idx, 64'(d_grants), 64'(v.dg));
  endtask

  initial begin
    int ig0, dg0, ig1, dg1, ig2;
    i_adr = I_ADR; i_sel = I_SEL; i_dat_m = I_DAT;
    d_adr = D_ADR; d_sel = D_SEL; d_dat_m = D_DAT;
    m_dat_s = M_DAT;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // icache read, memory acks on the 5th served cycle
    add(0,1,0,0,0,0,G_N,0,0);
    for (int k = 0; k < 4; k++) add(0,1,0,0,0,0,G_I,1,0);
    add(0,1,0,0,0,1,G_I,1,0);
    add(0,0,0,0,0,0,G_N,1,0);
    // reset, then both request continuously for 4 transactions
    add(1,0,0,0,0,0,G_N,1,0);
    add(0,1,0,1,0,0,G_N,0,0);
    add(0,1,0,1,0,1,G_D,0,1);
    add(0,1,0,1,0,0,G_N,0,1);
    add(0,1,0,1,0,1,PRIO ? G_D : G_I, PRIO ? 0 : 1, PRIO ? 2 : 1);
    add(0,1,0,1,0,0,G_N,           PRIO ? 0 : 1, PRIO ? 2 : 1);
    add(0,1,0,1,0,1,G_D,           PRIO ? 0 : 1, PRIO ? 3 : 2);
    add(0,1,0,1,0,0,G_N,           PRIO ? 0 : 1, PRIO ? 3 : 2);
    add(0,1,0,1,0,1,PRIO ? G_D : G_I, PRIO ? 0 : 2, PRIO ? 4 : 2);
    add(0,0,0,0,0,0,G_N,           PRIO ? 0 : 2, PRIO ? 4 : 2);
    // dcache write in progress while icache waits; stray ack in IDLE ignored
    ig0 = PRIO ? 0 : 2; dg0 = PRIO ? 4 : 2;
    add(0,0,0,1,1,0,G_N,ig0,dg0);
    add(0,1,0,1,1,0,G_D,ig0,dg0+1);
    add(0,1,0,1,1,0,G_D,ig0,dg0+1);
    add(0,1,0,1,1,1,G_D,ig0,dg0+1);
    add(0,1,0,0,0,1,G_N,ig0,dg0+1);
    add(0,1,0,0,0,1,G_I,ig0+1,dg0+1);
    add(0,0,0,0,0,0,G_N,ig0+1,dg0+1);
    // icache abort, then late memory ack
    ig1 = ig0 + 1; dg1 = dg0 + 1;
    add(0,1,0,0,0,0,G_N,ig1,dg1);
    add(0,1,0,0,0,0,G_I,ig1+1,dg1);
    add(0,0,0,0,0,0,G_I,ig1+1,dg1);
    add(0,0,0,0,0,1,G_N,ig1+1,dg1);
    // reset mid-SERVE_D with ack one cycle later
    ig2 = ig1 + 1;
    add(0,0,0,1,0,0,G_N,ig2,dg1);
    add(1,0,0,1,0,0,G_D,ig2,dg1+1);
    add(0,0,0,0,0,1,G_N,0,0);
    add(0,0,0,0,0,0,G_N,0,0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    begin
      vec_t r0;
      r0.rst = 0; r0.ir = 0; r0.iw = 0; r0.dr = 0; r0.dw = 0; r0.mack = 0;
      r0.gnt = G_N; r0.ig = 4'd0; r0.dg = 4'd0;
      check_vec(-1, r0);
    end

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].ir, vecs[i].iw, vecs[i].dr, vecs[i].dw, vecs[i].mack);
      #1;
      check_vec(i, vecs[i]);
    end

    // 20 back-to-back dcache transactions: counter saturates at 15
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("sat_idle_mcyc", k, 64'(m_cyc), 64'd0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      #1;
      chk("sat_d_ack", k, 64'(d_ack), 64'd1);
      chk("sat_d_grants", k, 64'(d_grants), 64'((k + 1 > 15) ? 15 : k + 1));
      chk("sat_i_grants", k, 64'(i_grants), 64'd0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("sat_final", 20, 64'(d_grants), 64'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_mem_arbiter_rr.md
# wb_mem_arbiter_rr

Two-master to one-slave Wishbone arbiter that shares the single physical-memory bus between the instruction-cache and data-cache master ports of `mainpc`. It sits between the cache-side buses and the memory bus and grants whole transactions using round-robin fairness. It also keeps saturating per-master grant counters for performance analysis.

## Interface
Parameters:
- `ADR_W`, default 27: line address width.
- `DATA_W`, default 256: data width (one cache line).
- `SEL_W`, default 32: byte-select width; must equal `DATA_W/8`.
- `CNT_W`, default 32: grant-counter width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_cyc`, `i_stb`, `i_we` in 1 each: icache master control.
- `i_adr` in `ADR_W`; `i_sel` in `SEL_W`; `i_dat_m` in `DATA_W`: icache address, byte select and write data.
- `i_ack` out 1; `i_dat_s` out `DATA_W`: icache acknowledge and read data.
- `d_*` (same set as `i_*`): dcache master port.
- `m_cyc`, `m_stb`, `m_we` out 1 each; `m_adr` out `ADR_W`; `m_sel` out `SEL_W`; `m_dat_m` out `DATA_W`: memory-side request.
- `m_ack` in 1; `m_dat_s` in `DATA_W`: memory acknowledge and read data.
- `i_grants`, `d_grants` out `CNT_W`: saturating count of grants issued to each master.

## Operation
- A master request is `x_cyc & x_stb`.
- States: IDLE, SERVE_I, SERVE_D.
- `last` register: 0 means icache was granted last, 1 means dcache. Reset value is 0, so dcache wins the first tie.
- IDLE:
  - Only icache requests: go to SERVE_I.
  - Only dcache requests: go to SERVE_D.
  - Both request: grant the master that was not granted last.
  - No request: stay in IDLE.
  - On every grant: update `last` and increment that master's counter. Counters saturate at all-ones and do not wrap.
- SERVE_X:
  - `m_cyc/m_stb/m_we/m_adr/m_sel/m_dat_m` are driven combinationally from master X.
  - `x_ack = m_ack`; `x_dat_s = m_dat_s`.
  - The other master sees `ack = 0`.
  - On `m_ack`: return to IDLE.
  - If master X drops `x_cyc` before `m_ack` (abort): return to IDLE; the pending `m_ack` is not forwarded after the abort.
- IDLE outputs: `m_cyc = m_stb = m_we = 0`; `m_adr`, `m_sel`, `m_dat_m` are 0.
- `m_ack` received while in IDLE is ignored.
- `x_dat_s` is `m_dat_s` when X is granted, otherwise 0.
- Reset, including mid-transaction: state returns to IDLE, `last` = 0, counters = 0. All outputs are 0 from the cycle after the reset edge.

## Timing
- Grant latency: a request first seen in IDLE at edge N drives `m_cyc` during cycle N+1.
- Acknowledge path: `m_ack` to `x_ack` is combinational, zero cycles.
- Turnaround: after the `m_ack` cycle there is one IDLE cycle before the next grant. Back-to-back transactions alternate masters when both request continuously.
- Minimum transaction cost: 2 cycles plus memory latency.
- Counter update: counters change on the same edge that leaves IDLE.
- Starvation bound: a requesting master waits at most one full transaction of the other master.

## Configuration
- Macro `WB_ARB_DCACHE_PRIO_EN`.
- Defined: fixed priority. Dcache always wins simultaneous requests in IDLE; `last` is still maintained but not consulted.
- Undefined (default): round-robin as described above.
- All other behaviour is identical in both modes.

## Test plan
- Reset, then icache read at `i_adr = 0x40`, memory acks after 5 cycles:
  - `m_cyc` rises 1 cycle after the request.
  - `i_ack` pulses with `m_dat_s`.
  - `i_grants = 1`, `d_grants = 0`.
- Both masters request continuously for 4 transactions:
  - Grant order is D, I, D, I with one IDLE cycle between grants.
  - Counters end at 2 and 2.
  - With `WB_ARB_DCACHE_PRIO_EN`: order is D, D, D, D and `i_grants = 0`.
- Dcache write in progress, icache requests:
  - Icache waits; `i_ack` stays 0 throughout.
  - Icache is granted the cycle after the dcache transaction's IDLE cycle.
- Assert `rst` mid-SERVE_D, with `m_ack` arriving 1 cycle later:
  - All outputs are 0 and the counters are cleared.
  - `d_ack` stays 0.
- Icache drops `i_cyc` before `m_ack`:
  - Arbiter returns to IDLE.
  - A late `m_ack` produces no `i_ack` or `d_ack`.
- Preload `d_grants` near saturation with `CNT_W = 4` and run 20 dcache transactions:
  - Counter holds at 15.
